stream_mux: RTL and testbench
=============================

// Module: stream_mux
// PURPOSE
//  Parametrised N-channel, W-bit valid/ready stream multiplexer with one registered output stage.
//  Successor to the combinational 4:1 bit mux: generalised channel count and data width, adds
//  flow control, per-channel backpressure and optional round-robin arbitration.
//  Sits between multiple producer streams and a single consumer, e.g. shared-link front end.
// PARAMETERS
//  N     4              number of input channels (>=2)
//  W     8              data width per channel
//  SELW  $clog2(N)      width of sel / out_chan (derived; do not override)
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  sel        in   SELW   channel select (fixed-select mode only)
//  in_data    in   N*W    channel i data at [i*W +: W]
//  in_valid   in   N      per-channel valid
//  in_ready   out  N      per-channel ready (combinational)
//  out_data   out  W      registered output data
//  out_valid  out  1      registered output valid
//  out_ready  in   1      consumer ready
//  out_chan   out  SELW   source channel of the current out_data
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_chan=0, rr_ptr=N-1.
//  - Output stage is one register slice. load = !out_valid || out_ready.
//  - Chosen channel c: fixed mode c=sel; RR mode c=arbiter grant (below).
//  - in_ready[i] = load && (i==c) && c_is_valid_index; all other bits 0.
//  - Transfer on input i when in_valid[i] && in_ready[i]. Next edge: out_data<=in_data[c],
//    out_chan<=c, out_valid<=1. Latency input handshake -> out_valid: 1 cycle.
//  - If load && !in_valid[c]: out_valid<=0 at next edge (out_data/out_chan hold last value).
//  - Stall: out_valid && !out_ready -> out_data, out_chan, out_valid held stable; all in_ready=0.
//  - Full throughput: out_ready held 1 with continuous in_valid[c] -> one word per cycle, no bubbles.
//  - Simultaneous output drain and input accept in the same cycle allowed (load true).
//  - sel >= N (non-power-of-2 N): no channel chosen, all in_ready=0, no transfer.
//  - sel change mid-stall: no effect on held word; new sel applies at next load cycle.
//  - Reset asserted mid-transfer: in-flight word dropped, outputs to reset values immediately.
//  - Data of non-selected channels never reaches out_data; no combinational in->out path
//    except in_ready depending on out_ready and sel/in_valid.
// CONFIGURATION
//  Macro RR_ARB_EN:
//  - Defined: sel ignored. Grant = first i with in_valid[i], searching rr_ptr+1 .. rr_ptr+N
//    modulo N. rr_ptr <= granted index on each accepted transfer only; unchanged when stalled
//    or no valid. Grant computed each cycle (may move while stalled; only load-cycle grant counts).
//    No in_valid set -> no grant, all in_ready=0. After reset, channel 0 has top priority.
//  - Undefined: fixed-select mode as above; no rr_ptr register synthesised.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, out_data=0, out_chan=0 same cycle; in_ready=0 while reset.
//  2 Fixed sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> next cycle out_data=A5,
//    out_chan=2, out_valid=1; ch0/1/3 in_ready=0 throughout.
//  3 Backpressure: out_valid=1, out_ready=0 for 3 cycles with sel toggling -> out_data/out_chan
//    stable, in_ready=0; out_ready=1 -> word drained, new sel word loaded same edge.
//  4 Streaming: sel=1, ch1 sends 8'h01..8'h10 with out_ready=1 -> 16 words on 16 consecutive cycles, in order.
//  5 N=3: sel=3 with in_valid=3'b111 -> in_ready=0, out_valid stays 0.
//  6 RR_ARB_EN, N=4, all in_valid=1, out_ready=1 -> out_chan sequence 0,1,2,3,0; with only
//    ch1,ch3 valid -> 1,3,1,3; stall 2 cycles -> sequence resumes without skip or repeat.

Source files
------------

// File: rtl/stream_mux_if.sv
// stream_mux_if: bundles the N producer streams and the single consumer stream
// of stream_mux. The slave modport is the multiplexer's view; the master modport
// is the view of whatever drives the producers and sinks the consumer side.
interface stream_mux_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SELW = $clog2(N);

    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SELW-1:0] out_chan;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/stream_mux.sv
// stream_mux: N-channel, W-bit valid/ready stream multiplexer with a single
// registered output slice. Default build uses the external sel input to pick the
// source channel. Defining the macro RR_ARB_EN replaces sel with a round-robin
// arbiter that starts with channel 0 at top priority after reset.
module stream_mux #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [$clog2(N)-1:0] sel,
    stream_mux_if.slave          bus
);
    localparam int SELW = $clog2(N);

    logic            r_outValid;
    logic [W-1:0]    r_outData;
    logic [SELW-1:0] r_outChan;

    logic            w_load;
    logic            w_chanOk;
    logic [SELW-1:0] w_chan;
    logic [W-1:0]    w_selData;
    logic            w_selValid;
    logic            w_take;
    logic [N-1:0]    w_inReady;

    // The slice can accept a new word when it is empty or being drained this
    // cycle; holding off during reset keeps every in_ready low while rst_n is low.
    assign w_load = rst_n && (!r_outValid || bus.out_ready);

`ifdef RR_ARB_EN
    logic [SELW-1:0] r_rrPtr;
    logic [SELW-1:0] w_idx;
    logic            w_unusedSel;

    // sel has no meaning when the arbiter decides
    assign w_unusedSel = ^sel;

    // Round-robin grant: first valid channel after the previous winner
    always_comb begin
        w_chanOk = 1'b0;
        w_chan   = '0;
        w_idx    = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = SELW'((int'(r_rrPtr) + k) % N);
            if (!w_chanOk && bus.in_valid[w_idx]) begin
                w_chanOk = 1'b1;
                w_chan   = w_idx;
            end
        end
    end

    // Last winner drops to lowest priority; only a real transfer moves it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrPtr <= SELW'(N - 1);
        end else if (w_take) begin
            r_rrPtr <= w_chan;
        end
    end
`else
    // Fixed select: a sel beyond the last channel chooses nothing
    always_comb begin
        w_chan   = sel;
        w_chanOk = (int'(sel) < N);
    end
`endif

    // Route the chosen channel's data/valid and raise only its ready
    always_comb begin
        w_selData  = '0;
        w_selValid = 1'b0;
        w_inReady  = '0;
        for (int i = 0; i < N; i++) begin
            if (w_chanOk && (w_chan == SELW'(i))) begin
                w_selData    = bus.in_data[i*W +: W];
                w_selValid   = bus.in_valid[i];
                w_inReady[i] = w_load;
            end
        end
    end

    assign w_take       = w_load && w_selValid;
    assign bus.in_ready = w_inReady;

    // Output register slice: refill or empty on load, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outChan  <= '0;
        end else if (w_load) begin
            r_outValid <= w_take;
            if (w_take) begin
                r_outData <= w_selData;
                r_outChan <= w_chan;
            end
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_chan  = r_outChan;
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: scoreboard bench for stream_mux. Stimulus predicts accepted
// words from the channel-selection rules and queues them; a separate monitor
// compares every word the DUT presents. Also exercises an N=3 instance for the
// out-of-range select case. Works with or without RR_ARB_EN defined.
module tb_stream_mux;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = $clog2(N);

    typedef struct {
        int           chan;
        logic [W-1:0] data;
    } word_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [SELW-1:0] sel   = '0;
    logic [1:0]      sel3  = '0;

    int           total = 0;
    int           bad   = 0;
    word_t        sbq[$];
    bit           mFull = 1'b0;
    int           mPtr  = N - 1;
    logic [W-1:0] drvData [N];

    stream_mux_if #(.N(N), .W(W)) bus ();
    stream_mux_if #(.N(3), .W(W)) bus3 ();

    stream_mux #(.N(N), .W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sel  (sel),
        .bus  (bus)
    );

    stream_mux #(.N(3), .W(W)) dut3 (
        .clk  (clk),
        .rst_n(rst_n),
        .sel  (sel3),
        .bus  (bus3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus; predicts handshake and queues the accepted word
    task automatic applyStimulus(input logic [N-1:0] valid, input logic [SELW-1:0] s,
                                 input bit ready);
        int           c;
        bit           load;
        bit           accept;
        logic [N-1:0] expReady;
        word_t        w;
        @(negedge clk);
        sel           = s;
        bus.in_valid  = valid;
        bus.out_ready = ready;
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = drvData[i];
        #1;
        load = !mFull || ready;
`ifdef RR_ARB_EN
        c = -1;
        for (int k = 1; k <= N; k++) begin
            if (c < 0 && valid[(mPtr + k) % N]) c = (mPtr + k) % N;
        end
`else
        c = (int'(s) < N) ? int'(s) : -1;
`endif
        expReady = '0;
        if (load && c >= 0) expReady[c] = 1'b1;
        checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(mFull));
        accept = load && (c >= 0) && valid[c];
        if (accept) begin
            w.chan = c;
            w.data = drvData[c];
            sbq.push_back(w);
            mPtr = c;
        end
        if (load) mFull = accept;
    endtask

    // Assert reset with inputs that would otherwise be accepted; outputs must clear at once
    task automatic doReset();
        @(negedge clk);
        bus.in_valid  = '1;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("reset_out_chan", 32'(bus.out_chan), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
        sbq.delete();
        mFull = 1'b0;
        mPtr  = N - 1;
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = '0;
    endtask

    // Monitor: compare every presented word with the scoreboard head, pop on handshake
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.out_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL sb_empty: got word %0h chan %0d expected none",
                             bus.out_data, bus.out_chan);
                end else begin
                    checkOutput("out_data", 32'(bus.out_data), 32'(sbq[0].data));
                    checkOutput("out_chan", 32'(bus.out_chan), 32'(sbq[0].chan));
                    if (bus.out_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        bus.in_valid   = '0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus3.in_valid  = '0;
        bus3.in_data   = '0;
        bus3.out_ready = 1'b1;
        for (int i = 0; i < N; i++) drvData[i] = '0;

        $display("[TB] reset");
        doReset();

`ifndef RR_ARB_EN
        $display("[TB] N=3 out-of-range select");
        @(negedge clk);
        sel3          = 2'd3;
        bus3.in_valid = 3'b111;
        #1;
        checkOutput("n3_oob_ready", 32'(bus3.in_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("n3_oob_valid", 32'(bus3.out_valid), 32'd0);
            checkOutput("n3_oob_ready", 32'(bus3.in_ready), 32'd0);
        end
        sel3         = 2'd1;
        bus3.in_data = {8'h11, 8'h3C, 8'h22};
        #1;
        checkOutput("n3_sel1_ready", 32'(bus3.in_ready), 32'b010);
        @(negedge clk);
        bus3.in_valid = '0;
        #1;
        checkOutput("n3_sel1_valid", 32'(bus3.out_valid), 32'd1);
        checkOutput("n3_sel1_chan", 32'(bus3.out_chan), 32'd1);
        checkOutput("n3_sel1_data", 32'(bus3.out_data), 32'h3C);
`endif

        $display("[TB] single word on channel 2");
        for (int i = 0; i < N; i++) drvData[i] = 8'(8'h50 + i);
        drvData[2] = 8'hA5;
        applyStimulus(4'b0100, 2'd2, 1'b1);
        applyStimulus(4'b0000, 2'd2, 1'b1);
        checkOutput("ch2_out_data", 32'(bus.out_data), 32'hA5);
        checkOutput("ch2_out_chan", 32'(bus.out_chan), 32'd2);
        checkOutput("ch2_out_valid", 32'(bus.out_valid), 32'd1);
        applyStimulus(4'b0000, 2'd2, 1'b1);

        $display("[TB] backpressure with sel toggling");
        drvData[0] = 8'h11;
        drvData[3] = 8'h33;
        applyStimulus(4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b1111, 2'd1, 1'b0);
        applyStimulus(4'b1111, 2'd2, 1'b0);
        applyStimulus(4'b1111, 2'd3, 1'b0);
        applyStimulus(4'b1111, 2'd3, 1'b1);
        applyStimulus(4'b0000, 2'd3, 1'b1);

        $display("[TB] streaming 16 words on channel 1");
        for (int v = 1; v <= 16; v++) begin
            drvData[1] = 8'(v);
            applyStimulus(4'b0010, 2'd1, 1'b1);
        end
        applyStimulus(4'b0000, 2'd1, 1'b1);

        $display("[TB] arbitration patterns");
        doReset();
        for (int i = 0; i < N; i++) drvData[i] = 8'(8'hC0 + i);
        repeat (5) applyStimulus(4'b1111, 2'd0, 1'b1);
        repeat (4) applyStimulus(4'b1010, 2'd1, 1'b1);
        repeat (2) applyStimulus(4'b1010, 2'd3, 1'b0);
        repeat (4) applyStimulus(4'b1010, 2'd1, 1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < N; i++) drvData[i] = 8'($urandom);
            if (n == 150) doReset();
            applyStimulus(4'($urandom), 2'($urandom_range(0, N - 1)),
                          ($urandom_range(0, 3) != 0));
        end

        repeat (3) applyStimulus(4'b0000, 2'd0, 1'b1);
        checkOutput("sb_drain", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
